// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared widths, rounding modes and result type for the channel averager
// Contents:
//   acc_w()      accumulator width for a given sample width and window size
//   ch_w()       channel tag width, at least 1 bit
//   round_mode_e RND_FLOOR / RND_HALF_UP
//   sm_result_t  {sign, mag, avg}, fields sized to MAX_DATA_W (users take the low DATA_W bits)
package accel_pkg;

  localparam int MAX_DATA_W = 32;

  typedef enum logic {
    RND_FLOOR   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  typedef struct packed {
    logic                  sign;
    logic [MAX_DATA_W-1:0] mag;
    logic [MAX_DATA_W-1:0] avg;
  } sm_result_t;

  function automatic int acc_w(input int data_w, input int log2_win);
    return data_w + log2_win;
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

endpackage

// File: rtl/avg_sign_mag.sv
// rtl/avg_sign_mag.sv - window sum to rounded average plus sign/magnitude (combinational)
// Ports:
//   sum  in   ACC_W signed window sum
//   res  out  sm_result_t: avg sign-extended, mag zero-extended, sign = avg < 0
module avg_sign_mag
  import accel_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int LOG2_WIN = 7,
  parameter int ROUND    = 0,
  localparam int ACC_W   = acc_w(DATA_W, LOG2_WIN)
) (
  input  logic signed [ACC_W-1:0] sum,
  output sm_result_t              res
);

  // Half an LSB of the result, added before the shift when rounding half up.
  localparam logic signed [ACC_W:0] BIAS =
    (ROUND == int'(RND_HALF_UP)) ? ((ACC_W+1)'(1) << (LOG2_WIN - 1)) : '0;

  logic signed [ACC_W:0]  biased;
  logic [DATA_W-1:0]      avg;
  logic [DATA_W-1:0]      mag;
  logic                   neg;

  always_comb begin
    // One extra bit so the rounding bias cannot overflow the sum.
    biased = $signed({sum[ACC_W-1], sum}) + BIAS;
    // The mean of DATA_W-bit samples always fits in DATA_W bits.
    avg    = DATA_W'(biased >>> LOG2_WIN);
    neg    = avg[DATA_W-1];
    // The most negative value negates to itself, which read as unsigned is the exact magnitude.
    mag    = neg ? (DATA_W'(0) - avg) : avg;
    res.sign = neg;
    res.avg  = MAX_DATA_W'($signed(avg));
    res.mag  = MAX_DATA_W'(mag);
  end

endmodule

// File: rtl/multi_channel_averager.sv
// rtl/multi_channel_averager.sv - per-channel tumbling-window averager with one-deep output register
// Ports:
//   clk, rst (async, active-high), clr (sync clear of all channel state and overrun)
//   in_valid, in_ch, in_data      tagged signed sample; in_ch >= NUM_CH is ignored
//   out_valid, out_ready          one-deep result handshake
//   out_ch, out_avg, out_mag, out_sign  result payload, held until transfer
//   overrun                       sticky: a pending result was overwritten
module multi_channel_averager
  import accel_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int NUM_CH   = 3,
  parameter int LOG2_WIN = 7,
  parameter int ROUND    = 0,
  localparam int CH_W    = ch_w(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [CH_W-1:0]          in_ch,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [DATA_W-1:0]        out_avg,
  output logic [DATA_W-1:0]        out_mag,
  output logic                     out_sign,
  output logic                     overrun
);

  localparam int ACC_W = acc_w(DATA_W, LOG2_WIN);
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

  logic signed [ACC_W-1:0] acc [NUM_CH];
  logic [LOG2_WIN-1:0]     cnt [NUM_CH];

  logic                    accept;
  logic                    complete;
  logic signed [ACC_W-1:0] cur_acc;
  logic signed [ACC_W-1:0] sum;
  logic [LOG2_WIN-1:0]     cur_cnt;
  sm_result_t              res;

  always_comb begin
    accept  = in_valid && !clr && ({1'b0, in_ch} < NUM_CH_L);
    cur_acc = '0;
    cur_cnt = '0;
    if (accept) begin
      cur_acc = acc[in_ch];
      cur_cnt = cnt[in_ch];
    end
    // Includes the current sample, so on completion this is the full window.
    sum      = cur_acc + ACC_W'(in_data);
    complete = accept && (cur_cnt == '1);
  end

  avg_sign_mag #(
    .DATA_W   (DATA_W),
    .LOG2_WIN (LOG2_WIN),
    .ROUND    (ROUND)
  ) u_avg_sign_mag (
    .sum (sum),
    .res (res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i] <= '0;
        cnt[i] <= '0;
      end
    end else if (accept) begin
      if (complete) begin
        acc[in_ch] <= '0;
        cnt[in_ch] <= '0;
      end else begin
        acc[in_ch] <= sum;
        cnt[in_ch] <= cur_cnt + LOG2_WIN'(1);
      end
    end
  end

  // clr drops both pending and completing results but leaves the payload as it was.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_avg   <= '0;
      out_mag   <= '0;
      out_sign  <= 1'b0;
      overrun   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_ch    <= in_ch;
      out_avg   <= res.avg[DATA_W-1:0];
      out_mag   <= res.mag[DATA_W-1:0];
      out_sign  <= res.sign;
      if (out_valid && !out_ready) begin
        overrun <= 1'b1;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    if (DATA_W < MAX_DATA_W) begin : g_res_hi
      logic unused_res_hi;
      assign unused_res_hi = ^{res.avg[MAX_DATA_W-1:DATA_W], res.mag[MAX_DATA_W-1:DATA_W]};
    end
  endgenerate

endmodule
